input_deserializer: RTL

- Receiving end of the layer input path: accepts a word-serial stream of pixels (one dataWidth word per beat) and packs it into the parallel vector that a layer takes on its layerIn input.
- Raises a registered frame-valid once numWords words are collected.
- Holds the frame stable until the consumer acknowledges it, then re-arms for the next frame.
- Sits between the host/stream source and layer 0; outValid drives the layer's layerValid input.

---
 rtl/input_deserializer_if.sv | 30 +++
 rtl/input_deserializer.sv | 97 +++++++++
 2 files changed

// File: rtl/input_deserializer_if.sv
// rtl/input_deserializer_if.sv - word-serial stream in / parallel frame out bundle for input_deserializer
// DESER_SYNC_ERR_EN adds the resync error pulse and counter.
interface input_deserializer_if #(
   parameter int numWords     = 784,
   parameter int dataWidth    = 16,
   parameter int counterWidth = $clog2(numWords + 1)
);
   logic [dataWidth-1:0]          inData;
   logic                          inValid;
   logic                          inFirst;
   logic                          inReady;
   logic                          outAck;
   logic [dataWidth*numWords-1:0] deserializerOut;
   logic                          outValid;
   logic [counterWidth-1:0]       wordCount;
`ifdef DESER_SYNC_ERR_EN
   logic                          syncErr;
   logic [15:0]                   syncErrCount;

   modport master (output inData, inValid, inFirst, outAck,
                   input  inReady, deserializerOut, outValid, wordCount, syncErr, syncErrCount);
   modport slave  (input  inData, inValid, inFirst, outAck,
                   output inReady, deserializerOut, outValid, wordCount, syncErr, syncErrCount);
`else
   modport master (output inData, inValid, inFirst, outAck,
                   input  inReady, deserializerOut, outValid, wordCount);
   modport slave  (input  inData, inValid, inFirst, outAck,
                   output inReady, deserializerOut, outValid, wordCount);
`endif
endinterface

// File: rtl/input_deserializer.sv
// rtl/input_deserializer.sv - packs a word-serial pixel stream into one parallel layer frame
// DESER_SYNC_ERR_EN adds syncErr/syncErrCount reporting of mid-frame resyncs.
module input_deserializer #(
   parameter int numWords     = 784,
   parameter int dataWidth    = 16,
   parameter int counterWidth = $clog2(numWords + 1)
) (
   input logic                 clk,
   input logic                 reset,
   input_deserializer_if.slave bus
);
   typedef enum logic {FILL, FULL} state_t;

   state_t                        state_q, state_d;
   logic                          out_valid_q, out_valid_d;
   logic [counterWidth-1:0]       word_count_q, word_count_d;
   logic [dataWidth*numWords-1:0] data_q, data_d;
   logic                          in_ready;
   logic                          accept;
   logic [counterWidth-1:0]       write_idx;
   logic [counterWidth-1:0]       next_count;
`ifdef DESER_SYNC_ERR_EN
   logic                          sync_err_q, sync_err_d;
   logic [15:0]                   sync_err_count_q, sync_err_count_d;
`endif

   assign in_ready = (state_q == FILL);
   assign accept   = bus.inValid && in_ready;

   always_comb begin
      state_d      = state_q;
      out_valid_d  = out_valid_q;
      word_count_d = word_count_q;
      data_d       = data_q;
      // A resync beat restarts the frame at word 0 regardless of the current count.
      write_idx    = bus.inFirst ? '0 : word_count_q;
      next_count   = bus.inFirst ? counterWidth'(1) : word_count_q + counterWidth'(1);
`ifdef DESER_SYNC_ERR_EN
      sync_err_d       = 1'b0;
      sync_err_count_d = sync_err_count_q;
`endif
      if (accept) begin
         for (int k = 0; k < numWords; k++) begin
            if (write_idx == counterWidth'(k))
               data_d[k*dataWidth +: dataWidth] = bus.inData;
         end
         word_count_d = next_count;
         if (next_count == counterWidth'(numWords)) begin
            state_d     = FULL;
            out_valid_d = 1'b1;
         end
`ifdef DESER_SYNC_ERR_EN
         if (bus.inFirst && (word_count_q != '0)) begin
            sync_err_d = 1'b1;
            if (sync_err_count_q != 16'hFFFF)
               sync_err_count_d = sync_err_count_q + 16'd1;
         end
`endif
      end
      if ((state_q == FULL) && bus.outAck) begin
         state_d      = FILL;
         out_valid_d  = 1'b0;
         word_count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= FILL;
         out_valid_q  <= 1'b0;
         word_count_q <= '0;
         data_q       <= '0;
`ifdef DESER_SYNC_ERR_EN
         sync_err_q       <= 1'b0;
         sync_err_count_q <= 16'd0;
`endif
      end else begin
         state_q      <= state_d;
         out_valid_q  <= out_valid_d;
         word_count_q <= word_count_d;
         data_q       <= data_d;
`ifdef DESER_SYNC_ERR_EN
         sync_err_q       <= sync_err_d;
         sync_err_count_q <= sync_err_count_d;
`endif
      end
   end

   assign bus.inReady         = in_ready;
   assign bus.outValid        = out_valid_q;
   assign bus.wordCount       = word_count_q;
   assign bus.deserializerOut = data_q;
`ifdef DESER_SYNC_ERR_EN
   assign bus.syncErr      = sync_err_q;
   assign bus.syncErrCount = sync_err_count_q;
`endif
endmodule
